// File: rtl/sseg_pkg.sv
// Shared constants and types for the four-digit seven-segment scan controller.
package sseg_pkg;

    localparam int unsigned N_DIGITS = 4;
    localparam int unsigned NIB_W    = 4;
    localparam int unsigned SEG_W    = 7;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // One display update: four hex nibbles plus per-digit dp and enable
    typedef struct packed {
        logic [N_DIGITS*NIB_W-1:0] data;
        logic [N_DIGITS-1:0]       dp;
        logic [N_DIGITS-1:0]       en;
    } disp_word_t;

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (nibble)
            4'h0: seg_c = SEG_0;
            4'h1: seg_c = SEG_1;
            4'h2: seg_c = SEG_2;
            4'h3: seg_c = SEG_3;
            4'h4: seg_c = SEG_4;
            4'h5: seg_c = SEG_5;
            4'h6: seg_c = SEG_6;
            4'h7: seg_c = SEG_7;
            4'h8: seg_c = SEG_8;
            4'h9: seg_c = SEG_9;
            4'hA: seg_c = SEG_A;
            4'hB: seg_c = SEG_B;
            4'hC: seg_c = SEG_C;
            4'hD: seg_c = SEG_D;
            4'hE: seg_c = SEG_E;
            4'hF: seg_c = SEG_F;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit common-anode scan controller with blanking gaps and
// frame-aligned, double-buffered display updates.
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS = 100000,
    parameter int unsigned BLANK_TICKS = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [N_DIGITS*NIB_W-1:0] wr_data,
    input  logic [N_DIGITS-1:0]       wr_dp,
    input  logic [N_DIGITS-1:0]       wr_en,
    output logic [N_DIGITS-1:0]       an,
    output logic [SEG_W-1:0]          seg,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int unsigned MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int unsigned CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int unsigned IDX_W     = $clog2(N_DIGITS);

    scan_state_t         state_q, state_nx;
    logic [CNT_W-1:0]    cnt_q, cnt_nx;
    logic [IDX_W-1:0]    idx_q, idx_nx;
    disp_word_t          pend_q, pend_nx;
    disp_word_t          act_q, act_nx;
    logic                ready_nx;
    logic [N_DIGITS-1:0] an_nx;
    logic [SEG_W-1:0]    seg_nx;
    logic                dp_nx;
    logic                fs_nx;
    logic                slot_end;
    logic                boundary;
    logic [NIB_W-1:0]    nibble;
    logic [SEG_W-1:0]    glyph_c;

    // Nibble for the digit about to be lit; active only changes while
    // heading into BLANK, so the current active copy is always the right one
    assign nibble = act_q.data[{idx_nx, 2'b00} +: NIB_W];

    sseg_hex_decode u_decode (
        .nibble (nibble),
        .seg_c  (glyph_c)
    );

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_q      <= '0;
            act_q       <= '0;
            wr_ready    <= 1'b1;
            an          <= '1;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_nx;
            cnt_q       <= cnt_nx;
            idx_q       <= idx_nx;
            pend_q      <= pend_nx;
            act_q       <= act_nx;
            wr_ready    <= ready_nx;
            an          <= an_nx;
            seg         <= seg_nx;
            dp          <= dp_nx;
            frame_start <= fs_nx;
        end
    end

    // Slot sequencing, write/transfer handshake and next output values
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q + CNT_W'(1);
        idx_nx   = idx_q;
        pend_nx  = pend_q;
        act_nx   = act_q;
        ready_nx = wr_ready;
        an_nx    = '1;
        seg_nx   = SEG_BLANK;
        dp_nx    = 1'b1;

        slot_end = (state_q == BLANK) ? (cnt_q == CNT_W'(BLANK_TICKS - 1))
                                      : (cnt_q == CNT_W'(DIGIT_TICKS - 1));
        boundary = (state_q == SHOW) && slot_end && (idx_q == IDX_W'(N_DIGITS - 1));
        fs_nx    = boundary;

        if (slot_end) begin
            cnt_nx = '0;
            if (state_q == BLANK) begin
                state_nx = SHOW;
            end else begin
                state_nx = BLANK;
                idx_nx   = idx_q + IDX_W'(1);
            end
        end

        // Accept and transfer are exclusive: accept needs pending empty
        if (wr_valid && wr_ready) begin
            pend_nx  = '{data: wr_data, dp: wr_dp, en: wr_en};
            ready_nx = 1'b0;
        end else if (boundary && !wr_ready) begin
            act_nx   = pend_q;
            ready_nx = 1'b1;
        end

        if ((state_nx == SHOW) && act_q.en[idx_nx]) begin
            an_nx[idx_nx] = 1'b0;
            seg_nx        = glyph_c;
            dp_nx         = ~act_q.dp[idx_nx];
        end
    end

endmodule
